// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Takes up to two {pc, instr} pairs per cycle from fetch and compacts them into
// a circular buffer. Presents the two oldest entries to decode. A flush
// empties the queue. A registered empty pulse feeds the MIF-empty perf counter.

// Read lane: selects the entry at head+LANE from the packed entry array.
module fetch_queue_rd_lane #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int LANE  = 0,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [PW-1:0]                   head_i,
  input  logic [DEPTH-1:0][2*XLEN-1:0]    mem_i,
  output logic [XLEN-1:0]                 pc_o,
  output logic [XLEN-1:0]                 instr_o
);
  logic [PW-1:0] idx;

  // the pointer wraps naturally modulo DEPTH, so a head pair can straddle DEPTH-1 -> 0
  assign idx = head_i + PW'(LANE);
  assign {pc_o, instr_o} = mem_i[idx];
endmodule

module fetch_queue #(
  parameter int XLEN           = 32,
  parameter int FRONTEND_WIDTH = 2,
  parameter int DEPTH          = 8,
  localparam int PW            = $clog2(DEPTH),
  localparam int CW            = PW + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic [1:0]                  enq_valid_i,
  input  logic [2*XLEN-1:0]           enq_pc_i,
  input  logic [2*XLEN-1:0]           enq_instr_i,
  output logic                        enq_ready_o,
  output logic [1:0]                  deq_valid_o,
  output logic [2*XLEN-1:0]           deq_pc_o,
  output logic [2*XLEN-1:0]           deq_instr_o,
  input  logic [1:0]                  deq_pop_i,
  output logic                        if_empty_o,
  output logic [CW-1:0]               count_o
);

  logic [DEPTH-1:0][2*XLEN-1:0] mem_q;
  logic [PW-1:0]                head_q, head_d;
  logic [PW-1:0]                tail_q, tail_d;
  logic [PW-1:0]                tail_p1;
  logic [CW-1:0]                count_q, count_d;
  logic                         if_empty_q;
  logic [1:0]                   enq_n;
  logic                         enq_fire;
  logic [2*XLEN-1:0]            slot0, slot1;

  assign slot0   = {enq_pc_i[XLEN-1:0],      enq_instr_i[XLEN-1:0]};
  assign slot1   = {enq_pc_i[2*XLEN-1:XLEN], enq_instr_i[2*XLEN-1:XLEN]};
  assign enq_n   = {1'b0, enq_valid_i[0]} + {1'b0, enq_valid_i[1]};
  assign tail_p1 = tail_q + PW'(1);

  // need two free entries regardless of same-cycle pops; keeps deq_pop_i off this path
  assign enq_ready_o = (count_q <= CW'(DEPTH - 2));
  assign enq_fire    = enq_ready_o && (|enq_valid_i) && !flush_i;

  assign deq_valid_o = {count_q >= CW'(2), count_q != '0};
  assign count_o     = count_q;
  assign if_empty_o  = if_empty_q;

  // entry writes: compacted so the oldest valid slot always lands at tail
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_q[tail_q] <= enq_valid_i[0] ? slot0 : slot1;
      if (&enq_valid_i) mem_q[tail_p1] <= slot1;
    end
  end

  // next-state pointers/occupancy; pops act on pre-cycle contents, flush wins
  always_comb begin
    head_d  = head_q + PW'(deq_pop_i);
    tail_d  = tail_q + (enq_fire ? PW'(enq_n) : '0);
    count_d = count_q + (enq_fire ? CW'(enq_n) : '0) - CW'(deq_pop_i);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // pointer/occupancy state and the registered empty pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      if_empty_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if_empty_q <= (count_q == '0);
    end
  end

  for (genvar l = 0; l < FRONTEND_WIDTH; l++) begin : g_lane
    fetch_queue_rd_lane #(.XLEN(XLEN), .DEPTH(DEPTH), .LANE(l)) u_lane (
      .head_i  (head_q),
      .mem_i   (mem_q),
      .pc_o    (deq_pc_o[l*XLEN +: XLEN]),
      .instr_o (deq_instr_o[l*XLEN +: XLEN])
    );
  end

`ifndef SYNTHESIS
  // decode may never pop more than it was shown
  always @(posedge clk) begin
    if (!rst) assert (deq_pop_i != 2'd3 && CW'(deq_pop_i) <= count_q);
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed table, corner sequences, random vs queue model.
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush_i;
  logic [1:0]         enq_valid_i;
  logic [2*XLEN-1:0]  enq_pc_i, enq_instr_i;
  logic               enq_ready_o;
  logic [1:0]         deq_valid_o;
  logic [2*XLEN-1:0]  deq_pc_o, deq_instr_o;
  logic [1:0]         deq_pop_i;
  logic               if_empty_o;
  logic [CW-1:0]      count_o;

  fetch_queue #(.XLEN(XLEN), .FRONTEND_WIDTH(2), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_pc_i    (enq_pc_i),
    .enq_instr_i (enq_instr_i),
    .enq_ready_o (enq_ready_o),
    .deq_valid_o (deq_valid_o),
    .deq_pc_o    (deq_pc_o),
    .deq_instr_o (deq_instr_o),
    .deq_pop_i   (deq_pop_i),
    .if_empty_o  (if_empty_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  // reference model: program-order queue of {pc, instr}, plus last-cycle-empty flag
  logic [63:0] mq[$];
  logic        m_ife;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        fl;
    logic [1:0]  v;
    logic [31:0] p0, p1;
    logic [1:0]  pop;
    int          ecnt;
    logic        erdy;
    logic [1:0]  evld;
    logic [31:0] epc0, epc1;
    logic        c0, c1;
  } row_t;
  row_t tbl[17];

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("m_count", 64'(count_o), 64'(sz));
    chk("m_deq_valid", 64'(deq_valid_o), {62'd0, sz >= 2, sz >= 1});
    chk("m_enq_ready", 64'(enq_ready_o), 64'((DEPTH - sz) >= 2));
    chk("m_if_empty", 64'(if_empty_o), 64'(m_ife));
    if (sz >= 1) chk("m_slot0", {deq_pc_o[31:0], deq_instr_o[31:0]}, mq[0]);
    if (sz >= 2) chk("m_slot1", {deq_pc_o[63:32], deq_instr_o[63:32]}, mq[1]);
  endtask

  // one clock: check current outputs, apply inputs across the edge, advance the model
  task automatic cyc(input logic fl, input logic [1:0] v, input logic [31:0] p0,
                     input logic [31:0] p1, input logic [1:0] pop);
    logic rdy;
    check_model();
    flush_i     = fl;
    enq_valid_i = v;
    enq_pc_i    = {p1, p0};
    enq_instr_i = {ins_of(p1), ins_of(p0)};
    deq_pop_i   = pop;
    @(posedge clk);
    rdy   = (DEPTH - mq.size()) >= 2;
    m_ife = (mq.size() == 0);
    if (fl) mq.delete();
    else begin
      repeat (int'(pop)) void'(mq.pop_front());
      if (rdy && v[0]) mq.push_back({p0, ins_of(p0)});
      if (rdy && v[1]) mq.push_back({p1, ins_of(p1)});
    end
    #1;
    flush_i = 1'b0; enq_valid_i = 2'b00; deq_pop_i = 2'b00;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_count"}, 64'(count_o), 64'd0);
    chk({tag, "_valid"}, 64'(deq_valid_o), 64'd0);
    chk({tag, "_ready"}, 64'(enq_ready_o), 64'd1);
    chk({tag, "_if_empty"}, 64'(if_empty_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b0, 2'b11, 32'h0,     32'h4,   2'd0, 2, 1'b1, 2'b11, 32'h0,   32'h4,   1'b1, 1'b1};
    tbl[1]  = '{1'b0, 2'b11, 32'h8,     32'hC,   2'd0, 4, 1'b1, 2'b11, 32'h0,   32'h4,   1'b1, 1'b1};
    tbl[2]  = '{1'b0, 2'b11, 32'h10,    32'h14,  2'd0, 6, 1'b1, 2'b11, 32'h0,   32'h4,   1'b1, 1'b1};
    tbl[3]  = '{1'b0, 2'b11, 32'h18,    32'h1C,  2'd0, 8, 1'b0, 2'b11, 32'h0,   32'h4,   1'b1, 1'b1};
    tbl[4]  = '{1'b0, 2'b11, 32'h20,    32'h24,  2'd0, 8, 1'b0, 2'b11, 32'h0,   32'h4,   1'b1, 1'b1};
    tbl[5]  = '{1'b0, 2'b00, 32'h0,     32'h0,   2'd2, 6, 1'b1, 2'b11, 32'h8,   32'hC,   1'b1, 1'b1};
    tbl[6]  = '{1'b0, 2'b00, 32'h0,     32'h0,   2'd2, 4, 1'b1, 2'b11, 32'h10,  32'h14,  1'b1, 1'b1};
    tbl[7]  = '{1'b0, 2'b00, 32'h0,     32'h0,   2'd2, 2, 1'b1, 2'b11, 32'h18,  32'h1C,  1'b1, 1'b1};
    tbl[8]  = '{1'b0, 2'b00, 32'h0,     32'h0,   2'd2, 0, 1'b1, 2'b00, 32'h0,   32'h0,   1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'b10, 32'hDEAD0, 32'h104, 2'd0, 1, 1'b1, 2'b01, 32'h104, 32'h0,   1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'b01, 32'h108,   32'h0,   2'd0, 2, 1'b1, 2'b11, 32'h104, 32'h108, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 2'b11, 32'h200,   32'h204, 2'd0, 4, 1'b1, 2'b11, 32'h104, 32'h108, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 2'b11, 32'h208,   32'h20C, 2'd0, 6, 1'b1, 2'b11, 32'h104, 32'h108, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 2'b11, 32'h40,    32'h44,  2'd2, 6, 1'b1, 2'b11, 32'h200, 32'h204, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 2'b00, 32'h0,     32'h0,   2'd2, 4, 1'b1, 2'b11, 32'h208, 32'h20C, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 2'b00, 32'h0,     32'h0,   2'd2, 2, 1'b1, 2'b11, 32'h40,  32'h44,  1'b1, 1'b1};
    tbl[16] = '{1'b0, 2'b00, 32'h0,     32'h0,   2'd2, 0, 1'b1, 2'b00, 32'h0,   32'h0,   1'b0, 1'b0};

    rst = 1'b1; flush_i = 1'b0; enq_valid_i = '0; enq_pc_i = '0; enq_instr_i = '0; deq_pop_i = '0;
    mq.delete(); m_ife = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst0");
    rst = 1'b0;

    // directed table: fill to full, overflow ignored, drain, compaction, push/pop at 6
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].fl, tbl[i].v, tbl[i].p0, tbl[i].p1, tbl[i].pop);
      chk($sformatf("t%0d_count", i), 64'(count_o), 64'(tbl[i].ecnt));
      chk($sformatf("t%0d_ready", i), 64'(enq_ready_o), 64'(tbl[i].erdy));
      chk($sformatf("t%0d_valid", i), 64'(deq_valid_o), 64'(tbl[i].evld));
      if (tbl[i].c0) chk($sformatf("t%0d_pc0", i), 64'(deq_pc_o[31:0]), 64'(tbl[i].epc0));
      if (tbl[i].c1) chk($sformatf("t%0d_pc1", i), 64'(deq_pc_o[63:32]), 64'(tbl[i].epc1));
    end

    // flush at count 4 with a simultaneous enqueue
    cyc(1'b0, 2'b11, 32'h500, 32'h504, 2'd0);
    cyc(1'b0, 2'b11, 32'h508, 32'h50C, 2'd0);
    chk("fl_pre_count", 64'(count_o), 64'd4);
    cyc(1'b1, 2'b11, 32'h300, 32'h304, 2'd0);
    chk("fl_count", 64'(count_o), 64'd0);
    chk("fl_valid", 64'(deq_valid_o), 64'd0);
    chk("fl_if_empty0", 64'(if_empty_o), 64'd0);
    cyc(1'b0, 2'b11, 32'h400, 32'h404, 2'd0);
    chk("fl_if_empty1", 64'(if_empty_o), 64'd1);
    chk("fl_absent", 64'(deq_pc_o[31:0]), 64'h400);
    chk("fl_count2", 64'(count_o), 64'd2);

    // wrap-around: steady push-2/pop-2 across the 7->0 boundary
    cyc(1'b1, 2'b00, 32'h0, 32'h0, 2'd0);
    cyc(1'b0, 2'b11, 32'h1000, 32'h1004, 2'd0);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("wr%0d_pc0", k), 64'(deq_pc_o[31:0]), 64'(32'h1000 + 32'(8 * k)));
      chk($sformatf("wr%0d_pc1", k), 64'(deq_pc_o[63:32]), 64'(32'h1004 + 32'(8 * k)));
      cyc(1'b0, 2'b11, 32'h1008 + 32'(8 * k), 32'h100C + 32'(8 * k), 2'd2);
    end
    chk("wr_count", 64'(count_o), 64'd2);

    // asynchronous reset mid-operation at count 5
    cyc(1'b1, 2'b00, 32'h0, 32'h0, 2'd0);
    cyc(1'b0, 2'b11, 32'h600, 32'h604, 2'd0);
    cyc(1'b0, 2'b11, 32'h608, 32'h60C, 2'd0);
    cyc(1'b0, 2'b01, 32'h610, 32'h0, 2'd0);
    chk("rs_pre_count", 64'(count_o), 64'd5);
    rst = 1'b1;
    #1;
    chk_reset_outs("rs_async");
    @(posedge clk);
    #1;
    chk_reset_outs("rs_held");
    rst = 1'b0;
    mq.delete(); m_ife = 1'b0;
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    chk("rs_if_empty1", 64'(if_empty_o), 64'd1);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    chk("rs_if_empty2", 64'(if_empty_o), 64'd1);

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      int sz, mx;
      logic fl;
      logic [1:0] v, pop;
      sz  = mq.size();
      mx  = (sz > 2) ? 2 : sz;
      pop = 2'($urandom_range(mx, 0));
      fl  = ($urandom_range(19, 0) == 0);
      v   = 2'($urandom);
      cyc(fl, v, {$urandom, 2'b00}, {$urandom, 2'b00}, pop);
    end
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
